// File: rtl/regfile_mp.sv
// Multi-ported register file with an issue/writeback busy scoreboard; x0 is hardwired to zero.
// Define REGFILE_BYPASS_EN to forward same-cycle write data and busy-clear to the read ports.
module regfile_mp #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32,
    parameter int unsigned NRD   = 2,
    parameter int unsigned NWR   = 2,
    localparam int unsigned AW   = $clog2(NREGS)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NRD-1:0][AW-1:0]     rd_addr,
    output logic [NRD-1:0][XLEN-1:0]   rd_data,
    output logic [NRD-1:0]             rd_busy,
    input  logic [NWR-1:0]             we,
    input  logic [NWR-1:0][AW-1:0]     wr_addr,
    input  logic [NWR-1:0][XLEN-1:0]   wr_data,
    input  logic                       iss_valid,
    input  logic [AW-1:0]              iss_rd,
    output logic [NREGS-1:0]           busy_vec
);

    logic [NREGS-1:0][XLEN-1:0] r_regs;
    logic [NREGS-1:0]           r_busy;

    logic [NREGS-1:0][XLEN-1:0] w_regs_nxt;
    logic [NREGS-1:0]           w_busy_nxt;
    logic [NWR-1:0]             w_wr_ok;
    logic                       w_iss_ok;

    // Writes and issues aimed at x0 are discarded here so x0 never changes.
    always_comb begin
        w_wr_ok = '0;
        for (int unsigned i = 0; i < NWR; i++) begin
            w_wr_ok[i] = we[i] && (wr_addr[i] != '0);
        end
        w_iss_ok = iss_valid && (iss_rd != '0);
    end

    // Ascending port order lets the highest-indexed port win address collisions.
    always_comb begin
        w_regs_nxt = r_regs;
        for (int unsigned i = 0; i < NWR; i++) begin
            if (w_wr_ok[i]) begin
                w_regs_nxt[wr_addr[i]] = wr_data[i];
            end
        end
    end

    // Writeback clears busy; an issue applied afterwards keeps the new producer pending.
    always_comb begin
        w_busy_nxt = r_busy;
        for (int unsigned i = 0; i < NWR; i++) begin
            if (w_wr_ok[i]) begin
                w_busy_nxt[wr_addr[i]] = 1'b0;
            end
        end
        if (w_iss_ok) begin
            w_busy_nxt[iss_rd] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_regs <= '0;
            r_busy <= '0;
        end else begin
            r_regs <= w_regs_nxt;
            r_busy <= w_busy_nxt;
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic [NRD-1:0][XLEN-1:0] w_rd_data;
    logic [NRD-1:0]           w_rd_busy;

    // Forwarding is suppressed during reset so reads stay zero while rst_n is low.
    always_comb begin
        w_rd_data = '0;
        w_rd_busy = '0;
        for (int unsigned j = 0; j < NRD; j++) begin
            w_rd_data[j] = r_regs[rd_addr[j]];
            w_rd_busy[j] = r_busy[rd_addr[j]];
            for (int unsigned i = 0; i < NWR; i++) begin
                if (rst_n && w_wr_ok[i] && (wr_addr[i] == rd_addr[j])) begin
                    w_rd_data[j] = wr_data[i];
                    w_rd_busy[j] = w_iss_ok && (iss_rd == rd_addr[j]);
                end
            end
        end
    end

    assign rd_data = w_rd_data;
    assign rd_busy = w_rd_busy;
`else
    logic [NRD-1:0][XLEN-1:0] w_rd_data;
    logic [NRD-1:0]           w_rd_busy;

    always_comb begin
        w_rd_data = '0;
        w_rd_busy = '0;
        for (int unsigned j = 0; j < NRD; j++) begin
            w_rd_data[j] = r_regs[rd_addr[j]];
            w_rd_busy[j] = r_busy[rd_addr[j]];
        end
    end

    assign rd_data = w_rd_data;
    assign rd_busy = w_rd_busy;
`endif

    assign busy_vec = r_busy;

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios plus random traffic against an array model.
module tb_regfile_mp;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned NREGS = 32;
    localparam int unsigned NRD   = 2;
    localparam int unsigned NWR   = 2;
    localparam int unsigned AW    = $clog2(NREGS);

    logic                     clk;
    logic                     rst_n;
    logic [NRD-1:0][AW-1:0]   rd_addr;
    logic [NRD-1:0][XLEN-1:0] rd_data;
    logic [NRD-1:0]           rd_busy;
    logic [NWR-1:0]           we;
    logic [NWR-1:0][AW-1:0]   wr_addr;
    logic [NWR-1:0][XLEN-1:0] wr_data;
    logic                     iss_valid;
    logic [AW-1:0]            iss_rd;
    logic [NREGS-1:0]         busy_vec;

    int n_chk;
    int n_fail;

    logic [XLEN-1:0] m_reg  [NREGS];
    logic            m_busy [NREGS];

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .we       (we),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .iss_valid(iss_valid),
        .iss_rd   (iss_rd),
        .busy_vec (busy_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < int'(NREGS); r++) begin
            m_reg[r]  = '0;
            m_busy[r] = 1'b0;
        end
    endtask

    // Expected read result for one address given the current input drive.
    task automatic exp_read(input logic [AW-1:0] a, output logic [XLEN-1:0] d, output logic b);
        d = m_reg[a];
        b = m_busy[a];
        if (!rst_n) begin
            d = '0;
            b = 1'b0;
        end
`ifdef REGFILE_BYPASS_EN
        else begin
            for (int i = 0; i < int'(NWR); i++) begin
                if (we[i] && wr_addr[i] != '0 && wr_addr[i] == a) begin
                    d = wr_data[i];
                    b = iss_valid && (iss_rd == a);
                end
            end
        end
`endif
    endtask

    task automatic check_all(input string tag);
        logic [XLEN-1:0]  d;
        logic             b;
        logic [NREGS-1:0] bv;
        for (int j = 0; j < int'(NRD); j++) begin
            exp_read(rd_addr[j], d, b);
            chk({tag, "_data"}, 64'(rd_data[j]), 64'(d));
            chk({tag, "_busy"}, 64'(rd_busy[j]), 64'(b));
        end
        for (int r = 0; r < int'(NREGS); r++) bv[r] = m_busy[r];
        chk({tag, "_busyvec"}, 64'(busy_vec), 64'(bv));
    endtask

    // Advance one clock edge, applying the architectural update rules to the model.
    task automatic cycle();
        logic [XLEN-1:0] nr [NREGS];
        logic            nb [NREGS];
        nr = m_reg;
        nb = m_busy;
        for (int i = 0; i < int'(NWR); i++) begin
            if (we[i] && wr_addr[i] != '0) begin
                nr[wr_addr[i]] = wr_data[i];
                nb[wr_addr[i]] = 1'b0;
            end
        end
        if (iss_valid && iss_rd != '0) nb[iss_rd] = 1'b1;
        @(posedge clk);
        #1;
        if (rst_n) begin
            m_reg  = nr;
            m_busy = nb;
        end
    endtask

    task automatic idle();
        we        = '0;
        wr_addr   = '0;
        wr_data   = '0;
        iss_valid = 1'b0;
        iss_rd    = '0;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        rd_addr = '0;
        idle();
        model_reset();
        #3;

        // Reset: every address reads zero on every port.
        for (int a = 0; a < int'(NREGS); a++) begin
            for (int j = 0; j < int'(NRD); j++) rd_addr[j] = AW'(a);
            #1;
            chk("rst_rd0", 64'(rd_data[0]), 64'd0);
            chk("rst_rd1", 64'(rd_data[NRD-1]), 64'd0);
            chk("rst_bv", 64'(busy_vec), 64'd0);
        end

        // Writes and issues held off by reset across a clock edge.
        we = '1; wr_addr[0] = AW'(5); wr_addr[1] = AW'(6);
        wr_data[0] = 32'hCAFE0001; wr_data[1] = 32'hCAFE0002;
        iss_valid = 1'b1; iss_rd = AW'(5);
        rd_addr[0] = AW'(5); rd_addr[1] = AW'(6);
        @(posedge clk); #1;
        check_all("rst_hold");
        idle();
        rst_n = 1'b1;
        #1;
        check_all("post_rst");

        // Basic write then read; x0 ignores writes.
        we[0] = 1'b1; wr_addr[0] = AW'(5); wr_data[0] = 32'hDEADBEEF;
        cycle();
        idle();
        rd_addr[0] = AW'(5); rd_addr[1] = AW'(0);
        #1;
        chk("x5_const", 64'(rd_data[0]), 64'hDEADBEEF);
        check_all("x5");
        we[0] = 1'b1; wr_addr[0] = AW'(0); wr_data[0] = 32'h1234;
        iss_valid = 1'b1; iss_rd = AW'(0);
        cycle();
        idle();
        #1;
        chk("x0_const", 64'(rd_data[1]), 64'd0);
        chk("x0_busy", 64'(busy_vec[0]), 64'd0);

        // Same-address collision: higher port wins.
        we = '1; wr_addr[0] = AW'(7); wr_addr[1] = AW'(7);
        wr_data[0] = 32'h11; wr_data[1] = 32'h22;
        cycle();
        idle();
        rd_addr[0] = AW'(7);
        #1;
        chk("x7_const", 64'(rd_data[0]), 64'h22);
        check_all("x7");

        // Scoreboard: issue, write+reissue, plain write.
        iss_valid = 1'b1; iss_rd = AW'(3);
        cycle();
        idle();
        #1;
        chk("iss3", 64'(busy_vec[3]), 64'd1);
        we[1] = 1'b1; wr_addr[1] = AW'(3); wr_data[1] = 32'h333;
        iss_valid = 1'b1; iss_rd = AW'(3);
        cycle();
        idle();
        #1;
        chk("wr_iss3", 64'(busy_vec[3]), 64'd1);
        iss_valid = 1'b1; iss_rd = AW'(3);
        cycle();
        idle();
        #1;
        chk("reiss3", 64'(busy_vec[3]), 64'd1);
        we[0] = 1'b1; wr_addr[0] = AW'(3); wr_data[0] = 32'h444;
        cycle();
        idle();
        rd_addr[0] = AW'(3);
        #1;
        chk("clr3", 64'(busy_vec[3]), 64'd0);
        check_all("x3");

        // Same-cycle read of a register being written.
        we[0] = 1'b1; wr_addr[0] = AW'(9); wr_data[0] = 32'h1111;
        iss_valid = 1'b1; iss_rd = AW'(9);
        cycle();
        idle();
        we[0] = 1'b1; wr_addr[0] = AW'(9); wr_data[0] = 32'hA5A5;
        rd_addr[0] = AW'(9); rd_addr[1] = AW'(9);
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("byp_data", 64'(rd_data[0]), 64'hA5A5);
        chk("byp_busy", 64'(rd_busy[0]), 64'd0);
`else
        chk("nobyp_data", 64'(rd_data[0]), 64'h1111);
        chk("nobyp_busy", 64'(rd_busy[0]), 64'd1);
`endif
        check_all("x9_same");
        cycle();
        idle();
        #1;
        chk("x9_next", 64'(rd_data[1]), 64'hA5A5);
        chk("x9_nbusy", 64'(rd_busy[1]), 64'd0);

        // Random traffic, biased toward a few addresses to provoke collisions.
        for (int n = 0; n < 400; n++) begin
            logic [31:0] lim;
            lim = (n % 3 == 0) ? 32'(NREGS - 1) : 32'd7;
            for (int i = 0; i < int'(NWR); i++) begin
                we[i]      = 1'($urandom);
                wr_addr[i] = AW'($urandom_range(0, lim));
                wr_data[i] = XLEN'($urandom);
            end
            iss_valid = 1'($urandom);
            iss_rd    = AW'($urandom_range(0, lim));
            for (int j = 0; j < int'(NRD); j++) rd_addr[j] = AW'($urandom_range(0, lim));
            #1;
            check_all("rand");
            cycle();
        end
        idle();

        // Asynchronous reset mid-cycle while x4 holds data and is busy.
        we[0] = 1'b1; wr_addr[0] = AW'(4); wr_data[0] = 32'h55;
        cycle();
        idle();
        iss_valid = 1'b1; iss_rd = AW'(4);
        cycle();
        idle();
        rd_addr[0] = AW'(4); rd_addr[1] = AW'(4);
        #1;
        chk("x4_pre", 64'(rd_data[0]), 64'h55);
        chk("x4_prebusy", 64'(busy_vec[4]), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_data", 64'(rd_data[0]), 64'd0);
        chk("arst_bv", 64'(busy_vec), 64'd0);
        check_all("arst");
        @(negedge clk);
        rst_n = 1'b1;

        // First edge after reset release takes writes and issues.
        we[1] = 1'b1; wr_addr[1] = AW'(4); wr_data[1] = 32'h77;
        iss_valid = 1'b1; iss_rd = AW'(8);
        cycle();
        idle();
        rd_addr[1] = AW'(8);
        #1;
        chk("rel_x4", 64'(rd_data[0]), 64'h77);
        chk("rel_iss8", 64'(busy_vec[8]), 64'd1);
        check_all("rel");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
